// File: rtl/isa_pkg.sv
// Shared ISA definitions used by instruction fetch and execution control:
// opcode encodings, immediate-operand decode and the fetch sequencer states.
package isa_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] LDACI  = 8'd0;
    localparam logic [OPC_W-1:0] LDAC   = 8'd1;
    localparam logic [OPC_W-1:0] STAC   = 8'd2;
    localparam logic [OPC_W-1:0] MVACR1 = 8'd3;
    localparam logic [OPC_W-1:0] MVACR2 = 8'd4;
    localparam logic [OPC_W-1:0] MVACR3 = 8'd5;
    localparam logic [OPC_W-1:0] MVACR4 = 8'd6;
    localparam logic [OPC_W-1:0] MVR1AC = 8'd7;
    localparam logic [OPC_W-1:0] MVR2AC = 8'd8;
    localparam logic [OPC_W-1:0] MVR3AC = 8'd9;
    localparam logic [OPC_W-1:0] MVR4AC = 8'd10;
    localparam logic [OPC_W-1:0] LDDAC  = 8'd11;
    localparam logic [OPC_W-1:0] STDAC  = 8'd12;
    localparam logic [OPC_W-1:0] STACI  = 8'd13;
    localparam logic [OPC_W-1:0] ADD    = 8'd14;
    localparam logic [OPC_W-1:0] SUB    = 8'd15;
    localparam logic [OPC_W-1:0] MUL    = 8'd16;
    localparam logic [OPC_W-1:0] DIV    = 8'd17;
    localparam logic [OPC_W-1:0] AND_OP = 8'd18;
    localparam logic [OPC_W-1:0] OR_OP  = 8'd19;
    localparam logic [OPC_W-1:0] XOR_OP = 8'd20;
    localparam logic [OPC_W-1:0] NOT_OP = 8'd21;
    localparam logic [OPC_W-1:0] SHL    = 8'd22;
    localparam logic [OPC_W-1:0] SHR    = 8'd23;
    localparam logic [OPC_W-1:0] INAC   = 8'd24;
    localparam logic [OPC_W-1:0] DCAC   = 8'd25;
    localparam logic [OPC_W-1:0] CLRAC  = 8'd26;
    localparam logic [OPC_W-1:0] JPNZ   = 8'd27;
    localparam logic [OPC_W-1:0] ENDOP  = 8'd28;
    localparam logic [OPC_W-1:0] JUMP   = 8'd29;
    localparam logic [OPC_W-1:0] INR1   = 8'd30;
    localparam logic [OPC_W-1:0] INR2   = 8'd31;
    localparam logic [OPC_W-1:0] DCR1   = 8'd32;
    localparam logic [OPC_W-1:0] DCR2   = 8'd33;
    localparam logic [OPC_W-1:0] NOP    = 8'd34;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_FETCH,
        FS_OPC,
        FS_IMM,
        FS_ISSUE,
        FS_HALT
    } fetch_state_e;

    // Only these three opcodes are followed by an immediate byte; every other value is one byte.
    function automatic logic has_imm(input logic [OPC_W-1:0] opc);
        return (opc == LDACI) || (opc == STACI) || (opc == JPNZ);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory owner: loader writes when idle/halted, otherwise fetches opcode(+imm) and issues it.
// Latency: 3 cycles per 1-byte instruction, 4 per immediate instruction (start edge counted as first).
// Backpressure: instruction held stable in ISSUE until ins_ready; loader only accepted while idle/halted.
module instr_fetch_ctrl
    import isa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [2*DATA_WIDTH-1:0] load_instr,
    input  logic [ADDR_WIDTH-1:0]   load_addr,
    output logic                    load_ready,
    input  logic                    start,
    output logic                    im_we,
    output logic [2*DATA_WIDTH-1:0] im_w_instr,
    output logic [ADDR_WIDTH-1:0]   im_w_addr,
    output logic [ADDR_WIDTH-1:0]   im_r_addr,
    input  logic [DATA_WIDTH-1:0]   im_r_instr,
    output logic                    ins_valid,
    input  logic                    ins_ready,
    output logic [DATA_WIDTH-1:0]   ins_opcode,
    output logic [DATA_WIDTH-1:0]   ins_operand,
    output logic                    ins_has_imm,
    input  logic                    jump_valid,
    input  logic [ADDR_WIDTH-1:0]   jump_addr,
    output logic                    busy,
    output logic                    halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] END_OPC = DATA_WIDTH'(ENDOP);

    fetch_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;
    logic                    has_imm_q, has_imm_d;
    logic                    halted_q, halted_d;
    logic                    ins_valid_q, busy_q, load_ready_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    opc_imm;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        has_imm_d = has_imm_q;
        halted_d  = halted_q;
        rd_addr   = pc_q;
        opc_imm   = has_imm(OPC_W'(im_r_instr));

        case (state_q)
            FS_IDLE, FS_HALT: begin
                // A loader write in the same cycle wins; start is dropped, not deferred.
                if (!load_valid && start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                    state_d  = FS_FETCH;
                end
            end
            FS_FETCH: begin
                state_d = FS_OPC;
            end
            FS_OPC: begin
                opcode_d  = im_r_instr;
                has_imm_d = opc_imm;
                if (opc_imm) begin
                    rd_addr = pc_q + PC_ONE;
                    state_d = FS_IMM;
                end else begin
                    operand_d = '0;
                    pc_d      = pc_q + PC_ONE;
                    state_d   = FS_ISSUE;
                end
            end
            FS_IMM: begin
                operand_d = im_r_instr;
                pc_d      = pc_q + PC_TWO;
                state_d   = FS_ISSUE;
            end
            FS_ISSUE: begin
                if (ins_ready) begin
                    // ENDOP ends the program even if a redirect is offered alongside it.
                    if (opcode_q == END_OPC) begin
                        halted_d = 1'b1;
                        state_d  = FS_HALT;
                    end else begin
                        if (jump_valid) begin
                            pc_d = jump_addr;
                        end
                        state_d = FS_FETCH;
                    end
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_IDLE;
            pc_q         <= '0;
            opcode_q     <= '0;
            operand_q    <= '0;
            has_imm_q    <= 1'b0;
            halted_q     <= 1'b0;
            ins_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            opcode_q     <= opcode_d;
            operand_q    <= operand_d;
            has_imm_q    <= has_imm_d;
            halted_q     <= halted_d;
            ins_valid_q  <= (state_d == FS_ISSUE);
            busy_q       <= (state_d != FS_IDLE) && (state_d != FS_HALT);
            load_ready_q <= (state_d == FS_IDLE) || (state_d == FS_HALT);
        end
    end

    assign load_ready  = load_ready_q;
    assign im_we       = load_ready_q & load_valid;
    assign im_w_instr  = load_instr;
    assign im_w_addr   = load_addr;
    assign im_r_addr   = rd_addr;
    assign ins_valid   = ins_valid_q;
    assign ins_opcode  = opcode_q;
    assign ins_operand = operand_q;
    assign ins_has_imm = has_imm_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: byte-wide memory beside the DUT plus a program-walking reference model.
module tb_instr_fetch_ctrl;

    localparam logic [7:0] OP_END = 8'd28;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_instr;
    logic [7:0]  load_addr;
    logic        load_ready;
    logic        start;
    logic        im_we;
    logic [15:0] im_w_instr;
    logic [7:0]  im_w_addr;
    logic [7:0]  im_r_addr;
    logic [7:0]  im_r_instr;
    logic        ins_valid;
    logic        ins_ready;
    logic [7:0]  ins_opcode;
    logic [7:0]  ins_operand;
    logic        ins_has_imm;
    logic        jump_valid;
    logic [7:0]  jump_addr;
    logic        busy;
    logic        halted;

    int          total = 0;
    int          bad   = 0;
    int          gap;
    logic [7:0]  mpc;
    logic [7:0]  img [256];
    logic [7:0]  mem [256];
    bit          ended;

    instr_fetch_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_instr(load_instr), .load_addr(load_addr), .load_ready(load_ready),
        .start(start),
        .im_we(im_we), .im_w_instr(im_w_instr), .im_w_addr(im_w_addr),
        .im_r_addr(im_r_addr), .im_r_instr(im_r_instr),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_opcode(ins_opcode),
        .ins_operand(ins_operand), .ins_has_imm(ins_has_imm),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_we) begin
            mem[im_w_addr]              <= im_w_instr[7:0];
            mem[8'(im_w_addr + 8'd1)]   <= im_w_instr[15:8];
        end else begin
            im_r_instr <= mem[im_r_addr];
        end
    end

    function automatic bit m_imm(input logic [7:0] op);
        return (op == 8'd0) || (op == 8'd13) || (op == 8'd27);
    endfunction

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd13;
            2:       return 8'd27;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_instr = d;
        #1;
        chk("load_ready", load_ready, 1);
        chk("im_we", im_we, 1);
        chk("im_w_addr", im_w_addr, a);
        chk("im_w_instr", im_w_instr, d);
        @(posedge clk); #1;
        load_valid = 1'b0;
        img[a]        = d[7:0];
        img[a + 8'd1] = d[15:8];
    endtask

    task automatic wait_issue(input int n0);
        int n = n0;
        while (!ins_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        gap = n;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_halted_clr"}, halted, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_fetch_addr"}, im_r_addr, 0);
        mpc = 8'd0;
        wait_issue(1);
    endtask

    task automatic step(input string tag, input int stall, input bit jmp, input logic [7:0] ja,
                        output bit fin);
        logic [7:0] op;
        logic [7:0] opr;
        logic [7:0] nxt;
        bit         im;
        op  = img[mpc];
        im  = m_imm(op);
        opr = im ? img[8'(mpc + 8'd1)] : 8'd0;
        nxt = 8'(mpc + (im ? 8'd2 : 8'd1));
        chk({tag, "_valid"}, ins_valid, 1);
        chk({tag, "_opcode"}, ins_opcode, op);
        chk({tag, "_operand"}, ins_operand, opr);
        chk({tag, "_has_imm"}, ins_has_imm, im);
        chk({tag, "_latency"}, gap, im ? 4 : 3);
        chk({tag, "_pc"}, im_r_addr, nxt);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, ins_valid, 1);
            chk({tag, "_hold_opcode"}, ins_opcode, op);
            chk({tag, "_hold_operand"}, ins_operand, opr);
            chk({tag, "_hold_pc"}, im_r_addr, nxt);
        end
        ins_ready  = 1'b1;
        jump_valid = jmp;
        jump_addr  = ja;
        @(posedge clk); #1;
        ins_ready  = 1'b0;
        jump_valid = 1'b0;
        chk({tag, "_drop_valid"}, ins_valid, 0);
        fin = (op == OP_END);
        if (fin) begin
            chk({tag, "_halted"}, halted, 1);
            chk({tag, "_idle_busy"}, busy, 0);
            chk({tag, "_load_ready"}, load_ready, 1);
        end else begin
            mpc = jmp ? ja : nxt;
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_next_fetch"}, im_r_addr, mpc);
            wait_issue(1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_instr = '0;
        load_addr  = '0;
        start      = 1'b0;
        ins_ready  = 1'b0;
        jump_valid = 1'b0;
        jump_addr  = '0;
        #12;
        chk("rst_valid", ins_valid, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_im_we", im_we, 0);
        chk("rst_r_addr", im_r_addr, 0);
        chk("rst_opcode", ins_opcode, 0);
        chk("rst_operand", ins_operand, 0);
        chk("rst_has_imm", ins_has_imm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 256; a += 2) load(8'(a), 16'h2222);

        // Two 1-byte instructions back to back, then ENDOP.
        load(8'd0, 16'h1A18);
        load(8'd2, 16'h001C);
        do_start("t1");
        step("t1_inac", 0, 1'b0, 8'd0, ended);
        step("t1_clrac", 0, 1'b0, 8'd0, ended);
        step("t1_end", 0, 1'b0, 8'd0, ended);

        // Immediate instruction with a 5-cycle stall at ISSUE.
        load(8'd0, 16'h0900);
        load(8'd2, 16'h001C);
        do_start("t2");
        step("t2_ldaci", 5, 1'b0, 8'd0, ended);
        step("t2_end", 0, 1'b1, 8'd99, ended);

        // JPNZ taken and not taken.
        load(8'd0, 16'h281B);
        load(8'd40, 16'h001C);
        load(8'd2, 16'h001C);
        do_start("t3a");
        step("t3_jump", 0, 1'b1, 8'd40, ended);
        step("t3_end_a", 0, 1'b0, 8'd0, ended);
        do_start("t3b");
        step("t3_nojump", 2, 1'b0, 8'd0, ended);
        step("t3_end_b", 0, 1'b0, 8'd0, ended);

        // Immediate wraps from 255 to 0; paired write wraps as well.
        load(8'd255, 16'h0700);
        load(8'd1, 16'h001C);
        do_start("t4");
        step("t4_op7", 0, 1'b1, 8'd255, ended);
        step("t4_wrap", 1, 1'b0, 8'd0, ended);
        step("t4_end", 0, 1'b0, 8'd0, ended);
        load(8'd255, 16'hBEEF);
        chk("beef_lo_255", mem[255], 8'hEF);
        chk("beef_hi_0", mem[0], 8'hBE);

        // Reset asserted while the immediate byte is being read.
        load(8'd0, 16'h0900);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_busy_imm", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", ins_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_load_ready", load_ready, 1);
        chk("t5_rst_r_addr", im_r_addr, 0);
        chk("t5_rst_opcode", ins_opcode, 0);
        #1;
        rst_n = 1'b1;

        // load_valid and start together: write only, remain idle.
        @(posedge clk); #1;
        load_valid = 1'b1;
        start      = 1'b1;
        load_addr  = 8'h10;
        load_instr = 16'h3344;
        #1;
        chk("t6_im_we", im_we, 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        start      = 1'b0;
        img[8'h10] = 8'h44;
        img[8'h11] = 8'h33;
        chk("t6_mem", mem[8'h10], 8'h44);
        for (int i = 0; i < 4; i++) begin
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_valid", ins_valid, 0);
            @(posedge clk); #1;
        end
        load(8'd2, 16'h001C);
        do_start("t6r");
        step("t6_ldaci", 0, 1'b0, 8'd0, ended);
        step("t6_end", 0, 1'b0, 8'd0, ended);

        // Random programs, stalls and redirects against the model.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 40; k++) begin
                load(8'($urandom_range(0, 255)), {rbyte(), rbyte()});
            end
            do_start("rnd");
            ended = 1'b0;
            for (int k = 0; k < 14 && !ended; k++) begin
                step("rnd", int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     8'($urandom_range(0, 255)), ended);
            end
            if (!ended) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_valid", ins_valid, 0);
                chk("rnd_rst_busy", busy, 0);
                #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
